free_list_ctrl: RTL and testbench

Physical-register free-list controller for the rename stage of the out-of-order mips_core. It hands out free physical register tags to the renamer and accepts tags released at commit. It also holds one checkpoint of the allocation pointer, so a branch-mispredict flush returns every tag allocated after the checkpoint in a single cycle. It sits between the register map table, the active list and the commit logic.

---
 rtl/free_list_ctrl.sv | 118 +++++++++++
 tb/tb_free_list_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/free_list_ctrl.sv
// free_list_ctrl: physical-register free list for the rename stage.
// A circular buffer of free tags: the renamer allocates from head, commit
// releases onto tail. One checkpoint of head lets a mispredict flush return
// every tag allocated since the checkpoint in a single cycle.
module free_list_ctrl #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_req,
  output logic                 alloc_ready,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic                 release_valid,
  input  logic [TAG_WIDTH-1:0] release_tag,
  input  logic                 ckpt_save,
  input  logic                 ckpt_restore,
  output logic [TAG_WIDTH:0]   free_count,
  output logic                 err
);

  // Tags not covered by the reset mappings start out free.
  localparam int INIT_FREE = PHYS_REGS - ARCH_REGS;
  // A release is only accepted while the list holds fewer than this many tags.
  localparam logic [TAG_WIDTH:0] COUNT_LIMIT = (TAG_WIDTH + 1)'(PHYS_REGS - 1);

  logic [TAG_WIDTH-1:0] mem_reg [PHYS_REGS];
  logic [TAG_WIDTH-1:0] head_reg, head_next;
  logic [TAG_WIDTH-1:0] tail_reg, tail_next;
  logic [TAG_WIDTH-1:0] ckpt_head_reg, ckpt_head_next;
  logic [TAG_WIDTH:0]   count_reg, count_next;
  logic                 err_reg, err_next;

  logic                 alloc_fire;
  logic                 release_ok;
  logic                 release_bad;
  logic [TAG_WIDTH-1:0] rewind_dist;

  // Allocation handshake: restore blocks allocation so the flushed head is
  // never handed out in the same cycle it is being rewound.
  assign alloc_ready = (count_reg != '0) && !ckpt_restore;
  assign alloc_tag   = mem_reg[head_reg];
  assign alloc_fire  = alloc_req && alloc_ready;

  // Tag 0 is never free (it is a reset mapping); a near-full list means a
  // double release somewhere upstream.
  assign release_ok  = release_valid && (release_tag != '0) && (count_reg < COUNT_LIMIT);
  assign release_bad = release_valid && !release_ok;

  // Tags allocated since the checkpoint; pointer subtraction wraps naturally.
  assign rewind_dist = head_reg - ckpt_head_reg;

  // Next-state for pointers, count, checkpoint and the sticky error flag.
  always_comb begin
    head_next      = head_reg;
    tail_next      = tail_reg;
    ckpt_head_next = ckpt_head_reg;
    count_next     = count_reg;
    err_next       = err_reg | release_bad;

    if (release_ok) begin
      tail_next = tail_reg + 1'b1;
    end

    if (ckpt_restore) begin
      // Restore wins over save and allocation; a concurrent release still lands.
      head_next  = ckpt_head_reg;
      count_next = count_reg + {1'b0, rewind_dist} + {{TAG_WIDTH{1'b0}}, release_ok};
    end else begin
      head_next  = head_reg + {{(TAG_WIDTH-1){1'b0}}, alloc_fire};
      count_next = count_reg - {{TAG_WIDTH{1'b0}}, alloc_fire}
                             + {{TAG_WIDTH{1'b0}}, release_ok};
      if (ckpt_save) begin
        // Saved pointer sits past the tag allocated this cycle.
        ckpt_head_next = head_next;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg      <= '0;
      tail_reg      <= TAG_WIDTH'(INIT_FREE);
      ckpt_head_reg <= '0;
      count_reg     <= (TAG_WIDTH + 1)'(INIT_FREE);
      err_reg       <= 1'b0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      ckpt_head_reg <= ckpt_head_next;
      count_reg     <= count_next;
      err_reg       <= err_next;
    end
  end

  // Tag storage: each entry has its own reset value, so it lives in flops.
  generate
    for (genvar gi = 0; gi < PHYS_REGS; gi++) begin : g_entry
      localparam logic [TAG_WIDTH-1:0] RESET_TAG =
        (gi < INIT_FREE) ? TAG_WIDTH'(ARCH_REGS + gi) : '0;

      // Write the released tag into the tail slot.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= RESET_TAG;
        end else if (release_ok && (tail_reg == TAG_WIDTH'(gi))) begin
          mem_reg[gi] <= release_tag;
        end
      end
    end
  endgenerate

  assign free_count = count_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_free_list_ctrl.sv
// tb_free_list_ctrl: table-driven checks of the free list plus hand-written
// sequences for drain, refill, overflow and asynchronous reset.
module tb_free_list_ctrl;

  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_req = 1'b0;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          release_valid = 1'b0;
  logic [TW-1:0] release_tag = '0;
  logic          ckpt_save = 1'b0;
  logic          ckpt_restore = 1'b0;
  logic [TW:0]   free_count;
  logic          err;

  int checks_total  = 0;
  int checks_passed = 0;

  free_list_ctrl #(.PHYS_REGS(64), .ARCH_REGS(32), .TAG_WIDTH(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_req     (alloc_req),
    .alloc_ready   (alloc_ready),
    .alloc_tag     (alloc_tag),
    .release_valid (release_valid),
    .release_tag   (release_tag),
    .ckpt_save     (ckpt_save),
    .ckpt_restore  (ckpt_restore),
    .free_count    (free_count),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       alloc;
    logic       rel;
    int         rel_tag;
    logic       save;
    logic       restore;
    logic       exp_ready;  // before the edge
    int         exp_tag;    // checked only when exp_ready
    int         exp_count;  // after the edge
    logic       exp_err;    // after the edge
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic vec_t mk(input logic a, input logic r, input int rt, input logic s,
                              input logic rs, input logic er, input int et, input int ec,
                              input logic ee);
    vec_t v;
    v.alloc = a; v.rel = r; v.rel_tag = rt; v.save = s; v.restore = rs;
    v.exp_ready = er; v.exp_tag = et; v.exp_count = ec; v.exp_err = ee;
    return v;
  endfunction

  // Drive one cycle of inputs (called just after a rising edge).
  task automatic drive(input logic a, input logic r, input int rt, input logic s, input logic rs);
    alloc_req = a; release_valid = r; release_tag = TW'(rt);
    ckpt_save = s; ckpt_restore = rs;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.alloc, v.rel, v.rel_tag, v.save, v.restore);
    #1;
    check($sformatf("vec%0d ready", idx), int'(alloc_ready), int'(v.exp_ready));
    if (v.exp_ready) check($sformatf("vec%0d tag", idx), int'(alloc_tag), v.exp_tag);
    @(posedge clk); #1;
    check($sformatf("vec%0d count", idx), int'(free_count), v.exp_count);
    check($sformatf("vec%0d err", idx), int'(err), int'(v.exp_err));
    drive(0, 0, 0, 0, 0);
    $display("vec%0d alloc=%0b rel=%0b/%0d save=%0b restore=%0b -> count=%0d err=%0b",
             idx, v.alloc, v.rel, v.rel_tag, v.save, v.restore, free_count, err);
  endtask

  initial begin
    //                alloc rel tag save rst | ready tag count err
    vecs[0]  = mk(1, 0, 0, 0, 0,  1, 32, 31, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0,  1, 33, 30, 0);
    vecs[2]  = mk(1, 0, 0, 1, 0,  1, 34, 29, 0);  // save: ckpt = 3
    vecs[3]  = mk(1, 0, 0, 0, 0,  1, 35, 28, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0,  1, 36, 27, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0,  1, 37, 26, 0);
    vecs[6]  = mk(1, 0, 0, 0, 1,  0,  0, 29, 0);  // restore: 26 + (6-3)
    vecs[7]  = mk(0, 0, 0, 0, 0,  1, 35, 29, 0);
    vecs[8]  = mk(1, 1, 7, 0, 1,  0,  0, 30, 0);  // restore+release+alloc
    vecs[9]  = mk(1, 0, 0, 0, 0,  1, 35, 29, 0);
    vecs[10] = mk(0, 0, 0, 1, 1,  0,  0, 30, 0);  // restore beats save
    vecs[11] = mk(1, 0, 0, 0, 0,  1, 35, 29, 0);
    vecs[12] = mk(0, 0, 0, 0, 1,  0,  0, 30, 0);  // ckpt still 3
    vecs[13] = mk(0, 0, 0, 0, 0,  1, 35, 30, 0);
    vecs[14] = mk(0, 1, 0, 0, 0,  1, 35, 30, 1);  // release tag 0: illegal
    vecs[15] = mk(1, 0, 0, 0, 0,  1, 35, 29, 1);  // err sticky

    // Reset state.
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset ready", int'(alloc_ready), 1);
    check("reset tag", int'(alloc_tag), 32);
    check("reset count", int'(free_count), 32);
    check("reset err", int'(err), 0);

    for (int i = 0; i < 16; i++) apply(vecs[i], i);

    // Asynchronous reset mid-cycle clears state without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async rst count", int'(free_count), 32);
    check("async rst err", int'(err), 0);
    check("async rst tag", int'(alloc_tag), 32);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    $display("async reset -> count=%0d err=%0b tag=%0d", free_count, err, alloc_tag);

    // Drain: 32 allocations hand out 32..63 in order.
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 0); #1;
      check($sformatf("drain%0d tag", i), int'(alloc_tag), 32 + i);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0); #1;
    check("empty ready", int'(alloc_ready), 0);
    check("empty count", int'(free_count), 0);
    $display("drain -> count=%0d ready=%0b", free_count, alloc_ready);

    // Allocation request on an empty list is ignored.
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("empty alloc count", int'(free_count), 0);

    // Refill while empty: no same-cycle bypass of the released tag.
    drive(1, 1, 5, 0, 0); #1;
    check("refill ready", int'(alloc_ready), 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0); #1;
    check("refill count", int'(free_count), 1);
    check("refill ready next", int'(alloc_ready), 1);
    check("refill tag", int'(alloc_tag), 5);
    $display("refill -> count=%0d tag=%0d", free_count, alloc_tag);

    // Allocate and release in the same cycle: count unchanged.
    drive(1, 1, 9, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0); #1;
    check("alloc+rel count", int'(free_count), 1);
    check("alloc+rel tag", int'(alloc_tag), 9);

    // Fill to 63, then an extra release is illegal.
    for (int i = 0; i < 62; i++) begin
      drive(0, 1, 1 + (i % 63), 0, 0);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0); #1;
    check("full count", int'(free_count), 63);
    check("full err", int'(err), 0);
    drive(0, 1, 12, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0); #1;
    check("overflow count", int'(free_count), 63);
    check("overflow err", int'(err), 1);
    $display("overflow -> count=%0d err=%0b", free_count, err);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
